// File: rtl/iram_uart_loader.sv
// UART 8N1 program loader: length byte N, then N payload bytes written to consecutive IRAM addresses.
// Optional trailing checksum byte (8-bit sum of payload) when IRAM_LOADER_CHECKSUM_EN is defined.

module iram_uart_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] BASE_ADDR    = 8'd0
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       loading,
    output logic       done,
    output logic       frame_err,
    output logic [7:0] byte_count
);

    // state    | meaning
    // RX_IDLE  | line idle, waiting for a falling edge
    // RX_START | timing to mid start bit to reject glitches
    // RX_DATA  | sampling 8 data bits, LSB first
    // RX_STOP  | sampling stop bit; emits byte_valid or a frame error
    // L_LEN    | waiting for the length byte
    // L_DATA   | writing payload bytes to IRAM
    // L_CKSUM  | waiting for the checksum byte (checksum builds only)

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef IRAM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {L_LEN, L_DATA, L_CKSUM} ld_state_t;
`else
    typedef enum logic [1:0] {L_LEN, L_DATA} ld_state_t;
`endif

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        byte_valid, stop_err;

    always_comb begin
        rx_state_nxt = rx_state;
        timer_nxt    = timer;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        byte_valid   = 1'b0;
        stop_err     = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_nxt = RX_START;
                    timer_nxt    = HALF_LAST;
                end
            end
            RX_START: begin
                if (timer == 16'd0) begin
                    if (!rx_sync) begin
                        rx_state_nxt = RX_DATA;
                        timer_nxt    = BIT_LAST;
                        bit_idx_nxt  = 3'd0;
                    end else begin
                        rx_state_nxt = RX_IDLE;
                    end
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            RX_DATA: begin
                if (timer == 16'd0) begin
                    shift_nxt   = {rx_sync, shift[7:1]};
                    timer_nxt   = BIT_LAST;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            RX_STOP: begin
                if (timer == 16'd0) begin
                    rx_state_nxt = RX_IDLE;
                    byte_valid   = rx_sync;
                    stop_err     = !rx_sync;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            timer    <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            rx_state <= rx_state_nxt;
            timer    <= timer_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
        end
    end

    ld_state_t  ld_state, ld_state_nxt;
    logic [7:0] remaining, remaining_nxt, byte_count_nxt, wr_addr_nxt, wr_data_nxt;
    logic       wr_en_nxt, loading_nxt, done_nxt, frame_err_nxt;
`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [7:0] cksum, cksum_nxt;
`endif

    // byte_valid and stop_err are combinational so the write lands one edge after the stop sample.
    always_comb begin
        ld_state_nxt   = ld_state;
        remaining_nxt  = remaining;
        byte_count_nxt = byte_count;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        wr_en_nxt      = 1'b0;
        loading_nxt    = loading;
        done_nxt       = done;
        frame_err_nxt  = frame_err;
`ifdef IRAM_LOADER_CHECKSUM_EN
        cksum_nxt      = cksum;
`endif
        if (stop_err) begin
            frame_err_nxt = 1'b1;
            loading_nxt   = 1'b0;
            ld_state_nxt  = L_LEN;
        end else if (byte_valid) begin
            unique case (ld_state)
                L_LEN: begin
                    done_nxt       = 1'b0;
                    frame_err_nxt  = 1'b0;
                    byte_count_nxt = 8'd0;
                    remaining_nxt  = shift;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    cksum_nxt      = 8'd0;
`endif
                    if (shift == 8'd0) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                        loading_nxt  = 1'b1;
                        ld_state_nxt = L_CKSUM;
`else
                        done_nxt     = 1'b1;
`endif
                    end else begin
                        loading_nxt  = 1'b1;
                        ld_state_nxt = L_DATA;
                    end
                end
                L_DATA: begin
                    wr_en_nxt      = 1'b1;
                    wr_data_nxt    = shift;
                    wr_addr_nxt    = BASE_ADDR + byte_count;
                    byte_count_nxt = byte_count + 8'd1;
                    remaining_nxt  = remaining - 8'd1;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    cksum_nxt      = cksum + shift;
`endif
                    if (remaining == 8'd1) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                        ld_state_nxt = L_CKSUM;
`else
                        loading_nxt  = 1'b0;
                        done_nxt     = 1'b1;
                        ld_state_nxt = L_LEN;
`endif
                    end
                end
`ifdef IRAM_LOADER_CHECKSUM_EN
                L_CKSUM: begin
                    loading_nxt  = 1'b0;
                    ld_state_nxt = L_LEN;
                    if (shift == cksum) begin
                        done_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
`endif
                default: ld_state_nxt = L_LEN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            ld_state   <= L_LEN;
            remaining  <= 8'd0;
            byte_count <= 8'd0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            wr_en      <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            cksum      <= 8'd0;
`endif
        end else begin
            ld_state   <= ld_state_nxt;
            remaining  <= remaining_nxt;
            byte_count <= byte_count_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            wr_en      <= wr_en_nxt;
            loading    <= loading_nxt;
            done       <= done_nxt;
            frame_err  <= frame_err_nxt;
`ifdef IRAM_LOADER_CHECKSUM_EN
            cksum      <= cksum_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_iram_uart_loader.sv
// Bench for iram_uart_loader: two instances (BASE_ADDR 00 and FE) share one rx line and are
// checked every cycle against a byte-stream protocol model; honours IRAM_LOADER_CHECKSUM_EN.

module tb_iram_uart_loader;

    localparam int CPB = 4;
    // 2 sync flops + edge detect register, half a bit to mid start, then 9 bit times to mid stop.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    logic [7:0] wr_addr0, wr_data0, byte_count0, wr_addr1, wr_data1, byte_count1;
    logic       wr_en0, loading0, done0, frame_err0, wr_en1, loading1, done1, frame_err1;

    iram_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h00)) dut0 (
        .CLK(clk), .rst(rst), .rx(rx),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_en(wr_en0), .loading(loading0),
        .done(done0), .frame_err(frame_err0), .byte_count(byte_count0)
    );

    iram_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'hFE)) dut1 (
        .CLK(clk), .rst(rst), .rx(rx),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_en(wr_en1), .loading(loading1),
        .done(done1), .frame_err(frame_err1), .byte_count(byte_count1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       ok;
    } ev_t;
    ev_t evq[$];

    // Model: 0 = expecting length, 1 = payload, 2 = checksum
    int         m_mode;
    logic [7:0] m_rem, m_cnt, m_sum, m_data, m_addr0, m_addr1;
    logic       m_done, m_ferr, m_load, m_we;

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_cnt = 0; m_sum = 0; m_data = 0;
        m_addr0 = 0; m_addr1 = 0; m_done = 0; m_ferr = 0; m_load = 0; m_we = 0;
        evq.delete();
    endtask

    task automatic model_apply(input logic [7:0] b, input logic ok);
        if (!ok) begin
            m_ferr = 1'b1;
            m_load = 1'b0;
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_done = 1'b0; m_ferr = 1'b0; m_cnt = 8'd0; m_rem = b; m_sum = 8'd0;
            if (b == 8'd0) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                m_mode = 2; m_load = 1'b1;
`else
                m_done = 1'b1;
`endif
            end else begin
                m_mode = 1; m_load = 1'b1;
            end
        end else if (m_mode == 1) begin
            m_we    = 1'b1;
            m_addr0 = 8'h00 + m_cnt;
            m_addr1 = 8'hFE + m_cnt;
            m_data  = b;
            m_cnt   = m_cnt + 8'd1;
            m_sum   = m_sum + b;
            m_rem   = m_rem - 8'd1;
            if (m_rem == 8'd0) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                m_mode = 2;
`else
                m_load = 1'b0; m_done = 1'b1; m_mode = 0;
`endif
            end
        end else begin
            m_load = 1'b0;
            m_mode = 0;
            if (b == m_sum) m_done = 1'b1;
            else            m_ferr = 1'b1;
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        m_we = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            model_apply(evq[0].b, evq[0].ok);
            evq.delete(0);
        end
        chk("dut0 {we,load,done,ferr,cnt,addr,data}",
            {wr_en0, loading0, done0, frame_err0, byte_count0, wr_addr0, wr_data0},
            {m_we, m_load, m_done, m_ferr, m_cnt, m_addr0, m_data});
        chk("dut1 {we,load,done,ferr,cnt,addr,data}",
            {wr_en1, loading1, done1, frame_err1, byte_count1, wr_addr1, wr_data1},
            {m_we, m_load, m_done, m_ferr, m_cnt, m_addr1, m_data});
    end

    task automatic reset_abort();
        chk("loading before mid-load reset", loading0, 1'b1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async reset dut0", {wr_en0, loading0, done0, frame_err0, byte_count0, wr_addr0, wr_data0}, 0);
        chk("async reset dut1", {wr_en1, loading1, done1, frame_err1, byte_count1, wr_addr1, wr_data1}, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge; abort_bit >= 0 resets the DUTs partway through the frame.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap, input int abort_bit);
        logic [9:0] fr;
        ev_t        e;
        fr = {stop, b, 1'b0};
        if (abort_bit < 0) begin
            e.cyc = cyc + LAT; e.b = b; e.ok = stop;
            evq.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == abort_bit) begin
                reset_abort();
                return;
            end
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (gap * CPB) @(negedge clk);
    endtask

    task automatic send_load(input logic [7:0] d[$]);
        logic [7:0] s;
        s = 8'd0;
        send_byte(8'(d.size()), 1'b1, int'($urandom_range(0, 1)), -1);
        foreach (d[i]) begin
            send_byte(d[i], 1'b1, int'($urandom_range(0, 1)), -1);
            s = s + d[i];
        end
`ifdef IRAM_LOADER_CHECKSUM_EN
        send_byte(s, 1'b1, 1, -1);
`endif
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (evq.size() > 0 && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        chk("event drain within bound", evq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] q[$];
        logic [7:0] s, b;
        int         n;
        logic       bad;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dut0", {wr_en0, loading0, done0, frame_err0, byte_count0, wr_addr0, wr_data0}, 0);
        chk("reset dut1", {wr_en1, loading1, done1, frame_err1, byte_count1, wr_addr1, wr_data1}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        d = '{8'hA1, 8'hB2, 8'hC3};
        send_load(d);
        wait_drain();
        chk("len3 byte_count", byte_count0, 8'd3);
        chk("len3 done", done0, 1'b1);
        chk("len3 loading", loading0, 1'b0);
        chk("len3 last addr base0", wr_addr0, 8'h02);
        chk("len3 last data", wr_data0, 8'hC3);
        chk("len3 last addr baseFE wraps", wr_addr1, 8'h00);
        chk("model pin count", m_cnt, 8'd3);

        d.delete();
        send_load(d);
        wait_drain();
        chk("len0 done", done0, 1'b1);
        chk("len0 byte_count", byte_count0, 8'd0);

        send_byte(8'd4, 1'b1, 0, -1);
        send_byte(8'h01, 1'b1, 0, -1);
        send_byte(8'h02, 1'b1, 0, -1);
        send_byte(8'h77, 1'b0, 1, -1);
        wait_drain();
        chk("abort frame_err", frame_err0, 1'b1);
        chk("abort byte_count", byte_count0, 8'd2);
        chk("abort done", done0, 1'b0);
        chk("abort loading", loading0, 1'b0);
        chk("abort last addr baseFE", wr_addr1, 8'hFF);
        d = '{8'h5A};
        send_load(d);
        wait_drain();
        chk("frame_err cleared by next load", frame_err0, 1'b0);
        chk("recovery done", done0, 1'b1);

        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch no frame_err", frame_err0, 1'b0);
        chk("glitch done kept", done0, 1'b1);

        for (int p = 0; p < 8; p++) begin
            q.delete();
            n = int'($urandom_range(1, 12));
            s = 8'd0;
            q.push_back(8'(n));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                q.push_back(b);
                s = s + b;
            end
`ifdef IRAM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) s = s ^ 8'h01;
            q.push_back(s);
`endif
            foreach (q[i]) begin
                bad = ($urandom_range(0, 19) == 0);
                send_byte(q[i], !bad, bad ? 1 : int'($urandom_range(0, 2)), -1);
            end
        end
        wait_drain();

        pulse_reset();
        repeat (3) @(negedge clk);
        send_byte(8'd3, 1'b1, 0, -1);
        send_byte(8'h11, 1'b1, 0, -1);
        send_byte(8'h22, 1'b1, 0, 5);
        repeat (60) @(negedge clk);
        chk("post-reset loading", loading0, 1'b0);
        chk("post-reset byte_count", byte_count0, 8'd0);

        d.delete();
        for (int k = 0; k < 255; k++) d.push_back(8'($urandom));
        send_load(d);
        wait_drain();
        chk("len255 byte_count", byte_count0, 8'd255);
        chk("len255 last addr base0", wr_addr0, 8'hFE);
        chk("len255 last addr baseFE", wr_addr1, 8'hFC);

`ifdef IRAM_LOADER_CHECKSUM_EN
        send_byte(8'd2, 1'b1, 0, -1);
        send_byte(8'h10, 1'b1, 0, -1);
        send_byte(8'h20, 1'b1, 0, -1);
        send_byte(8'h30, 1'b1, 1, -1);
        wait_drain();
        chk("cksum good done", done0, 1'b1);
        chk("cksum good frame_err", frame_err0, 1'b0);
        send_byte(8'd2, 1'b1, 0, -1);
        send_byte(8'h10, 1'b1, 0, -1);
        send_byte(8'h20, 1'b1, 0, -1);
        send_byte(8'h31, 1'b1, 1, -1);
        wait_drain();
        chk("cksum bad done", done0, 1'b0);
        chk("cksum bad frame_err", frame_err0, 1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
